// File: rtl/ws_result_drain.sv
// ws_result_drain: realigns skewed partial sums from the bottom PE row into vectors and queues them.
// Latency: lane 0 at cycle t is written at the end of t+row-1; out_valid rises in t+row if the FIFO was empty.
// Backpressure: the array cannot stall, so almost_full=(count+pending)>=depth throttles the feeder; excess vectors are dropped and overflow is set.
// Optional feature macro WS_DRAIN_RELU_EN: negative lanes are clamped to zero on write.
module ws_result_drain #(
  parameter int out_word_size = 16,
  parameter int row           = 3,
  parameter int depth         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [out_word_size-1:0]     Result_in [0:row-1],
  input  logic                         in_valid,
  output logic [out_word_size-1:0]     out_data [0:row-1],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         almost_full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow
);

  localparam int W  = out_word_size;
  localparam int CW = $clog2(depth + 1);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  // Aligned lanes leaving the deskew network, and the words actually stored.
  logic [W-1:0]  lane_dat [0:row-1];
  logic [W-1:0]  wr_data  [0:row-1];
  logic          wr_req;
  logic [CW-1:0] pending;

  // ------------------------------------------------------------------
  // Deskew: lane i is delayed (row-1-i) cycles so every lane of a vector
  // lines up with the last lane, which arrives combinationally.
  // ------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < row; gi++) begin : g_lane
    localparam int N = row - 1 - gi;
    if (N == 0) begin : g_comb
      assign lane_dat[gi] = Result_in[gi];
    end else begin : g_reg
      logic [W-1:0] sr_q [0:N-1];
      logic [W-1:0] sr_d [0:N-1];

      // Shift the lane word one stage deeper each cycle.
      always_comb begin
        sr_d[0] = Result_in[gi];
        for (int s = 1; s < N; s++) begin
          sr_d[s] = sr_q[s-1];
        end
      end

      // Deskew stage registers, cleared on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < N; s++) begin
            sr_q[s] <= '0;
          end
        end else begin
          for (int s = 0; s < N; s++) begin
            sr_q[s] <= sr_d[s];
          end
        end
      end

      assign lane_dat[gi] = sr_q[N-1];
    end
  end

  // ------------------------------------------------------------------
  // Valid delay line: tracks vectors launched into the deskew network.
  // Its output is the write request; its population is "pending".
  // ------------------------------------------------------------------
  if (row > 1) begin : g_vdl
    logic [row-2:0] vdl_q;
    logic [row-2:0] vdl_d;

    // Advance each launched vector's valid bit toward the write stage.
    always_comb begin
      vdl_d[0] = in_valid;
      for (int k = 1; k < row - 1; k++) begin
        vdl_d[k] = vdl_q[k-1];
      end
    end

    // Valid delay line register; reset discards in-flight vectors.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vdl_q <= '0;
      end else begin
        vdl_q <= vdl_d;
      end
    end

    // Count vectors already launched but not yet written.
    always_comb begin
      pending = '0;
      for (int k = 0; k < row - 1; k++) begin
        pending = pending + CW'(vdl_q[k]);
      end
    end

    assign wr_req = vdl_q[row-2];
  end else begin : g_novdl
    assign wr_req  = in_valid;
    assign pending = '0;
  end

  // Optional clamp of negative words before they enter the FIFO.
  always_comb begin
    for (int i = 0; i < row; i++) begin
`ifdef WS_DRAIN_RELU_EN
      wr_data[i] = lane_dat[i][W-1] ? '0 : lane_dat[i];
`else
      wr_data[i] = lane_dat[i];
`endif
    end
  end

  // ------------------------------------------------------------------
  // Vector FIFO. Full/empty come from count, never from pointer compare,
  // so a full FIFO can accept a write in the same cycle as a read.
  // ------------------------------------------------------------------
  logic [W-1:0]  mem_q [0:depth-1][0:row-1];
  logic [W-1:0]  mem_d [0:depth-1][0:row-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          rd_fire, wr_fire, full, drop;

  // Handshake, write/drop decision, pointer and occupancy next-state.
  always_comb begin
    rd_fire     = out_valid_q && out_ready;
    full        = (count_q == CW'(depth));
    wr_fire     = wr_req && (!full || rd_fire);
    drop        = wr_req && full && !rd_fire;

    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | drop;

    if (wr_fire) begin
      for (int i = 0; i < row; i++) begin
        mem_d[wr_ptr_q][i] = wr_data[i];
      end
      wr_ptr_d = (wr_ptr_q == AW'(depth - 1)) ? '0 : wr_ptr_q + AW'(1);
    end

    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == AW'(depth - 1)) ? '0 : rd_ptr_q + AW'(1);
    end

    if (wr_fire && !rd_fire) begin
      count_d = count_q + CW'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CW'(1);
    end

    out_valid_d = (count_d != '0);
  end

  // FIFO storage, pointers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < depth; e++) begin
        for (int i = 0; i < row; i++) begin
          mem_q[e][i] <= '0;
        end
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int e = 0; e < depth; e++) begin
        for (int i = 0; i < row; i++) begin
          mem_q[e][i] <= mem_d[e][i];
        end
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head of the FIFO straight from storage; stable while the pointer holds.
  always_comb begin
    for (int i = 0; i < row; i++) begin
      out_data[i] = mem_q[rd_ptr_q][i];
    end
  end

  assign almost_full = ({1'b0, count_q} + {1'b0, pending}) >= (CW+1)'(depth);
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ws_result_drain.sv
// Bench for ws_result_drain: directed vectors, expected vectors queued at issue time
// and checked by an independent output monitor; status signals checked inline.
`timescale 1ns/1ps
module tb_ws_result_drain;

  localparam int W     = 16;
  localparam int ROW   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [ROW-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Result_in [0:ROW-1];
  logic [W-1:0]  out_data  [0:ROW-1];
  logic          out_valid;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;

  int   checks   = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t hist [0:ROW-1];
  vec_t tv;
  vec_t relu_exp;

  always #5 clk = ~clk;

  ws_result_drain #(
    .out_word_size (W),
    .row           (ROW),
    .depth         (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Result_in   (Result_in),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow)
  );

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  function automatic vec_t got_vec();
    vec_t v;
    for (int i = 0; i < ROW; i++) v[i] = out_data[i];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane i carries the word of the vector launched i cycles earlier.
  task automatic drive(input logic v, input vec_t nv);
    for (int i = ROW - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = v ? nv : {ROW{16'hBEEF}};
    in_valid = v;
    for (int i = 0; i < ROW; i++) Result_in[i] = hist[i][i];
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      tick();
      drive(1'b0, '0);
      @(negedge clk);
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  // Output monitor: every accepted vector must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %0h expected no vector", got_vec());
      end else begin
        chk("out_data", got_vec(), exp_q.pop_front());
      end
    end
  end

  initial begin : main
    int sent;
    int first_af;
    int first_c4;

    for (int i = 0; i < ROW; i++) begin
      hist[i]      = {ROW{16'hBEEF}};
      Result_in[i] = 16'hBEEF;
    end

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", got_vec(), 0);
    tick();
    tick();
    rst = 1'b0;

    // Single vector {5,6,7}: out_valid only in cycle 3
    out_ready = 1'b1;
    tick(); drive(1'b1, mk(16'd5, 16'd6, 16'd7)); exp_q.push_back(mk(16'd5, 16'd6, 16'd7));
    @(negedge clk); chk("t1_c0_valid", out_valid, 0);
    tick(); drive(1'b0, '0);
    @(negedge clk); chk("t1_c1_valid", out_valid, 0);
    tick(); drive(1'b0, '0);
    @(negedge clk); chk("t1_c2_valid", out_valid, 0);
    tick(); drive(1'b0, '0);
    @(negedge clk); chk("t1_c3_valid", out_valid, 1); chk("t1_c3_count", count, 1);
    tick(); drive(1'b0, '0);
    @(negedge clk); chk("t1_c4_valid", out_valid, 0); chk("t1_c4_count", count, 0);

    // Streaming, obedient feeder, consumer stalls cycles 2..5
    sent = 0; first_af = -1; first_c4 = -1;
    for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
      tick();
      out_ready = !(cyc >= 2 && cyc < 6);
      if (!almost_full && sent < 8) begin
        tv = mk(16'h0100 + 16'(sent), 16'h0200 + 16'(sent), 16'h0300 + 16'(sent));
        drive(1'b1, tv);
        exp_q.push_back(tv);
        sent++;
      end else begin
        drive(1'b0, '0);
      end
      @(negedge clk);
      if (almost_full && first_af < 0) first_af = cyc;
      if (count == CW'(DEPTH) && first_c4 < 0) first_c4 = cyc;
    end
    chk("t2_sent", sent, 8);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_af_first_cycle", first_af, 4);
    chk("t2_af_before_full", (first_af >= 0) && (first_c4 < 0 || first_af < first_c4), 1);
    chk("t2_overflow", overflow, 0);

    // Fill to 4, then write and read in the same cycle while full
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tv = mk(16'h0A00 + 16'(k), 16'h0B00 + 16'(k), 16'h0C00 + 16'(k));
      drive(1'b1, tv);
      exp_q.push_back(tv);
    end
    for (int k = 0; k < 3; k++) begin tick(); drive(1'b0, '0); end
    @(negedge clk);
    chk("t4_full_count", count, 4);
    chk("t4_full_af", almost_full, 1);
    chk("t4_full_head", got_vec(), mk(16'h0A00, 16'h0B00, 16'h0C00));
    tick(); drive(1'b1, mk(16'h0A55, 16'h0B55, 16'h0C55)); exp_q.push_back(mk(16'h0A55, 16'h0B55, 16'h0C55));
    tick(); drive(1'b0, '0);
    tick(); drive(1'b0, '0); out_ready = 1'b1;
    @(negedge clk); chk("t4_rw_count_during", count, 4);
    tick(); drive(1'b0, '0); out_ready = 1'b0;
    @(negedge clk);
    chk("t4_rw_count_after", count, 4);
    chk("t4_rw_overflow", overflow, 0);
    chk("t4_rw_head", got_vec(), mk(16'h0A01, 16'h0B01, 16'h0C01));
    drain("t4");
    tick(); drive(1'b0, '0);
    @(negedge clk); chk("t4_empty_count", count, 0);

    // Overflow: 6 vectors into a stalled FIFO, last two dropped
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      tv = mk(16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k));
      drive(1'b1, tv);
      if (k < 4) exp_q.push_back(tv);
    end
    for (int k = 0; k < 3; k++) begin tick(); drive(1'b0, '0); end
    @(negedge clk);
    chk("t3_count", count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head", got_vec(), mk(16'h1000, 16'h2000, 16'h3000));
    drain("t3");
    tick(); drive(1'b0, '0);
    @(negedge clk);
    chk("t3_overflow_sticky", overflow, 1);
    chk("t3_empty_count", count, 0);

    // ReLU lanes {-3, 0, 9}
`ifdef WS_DRAIN_RELU_EN
    relu_exp = mk(16'h0000, 16'h0000, 16'h0009);
`else
    relu_exp = mk(16'hFFFD, 16'h0000, 16'h0009);
`endif
    out_ready = 1'b1;
    tick(); drive(1'b1, mk(16'hFFFD, 16'h0000, 16'h0009)); exp_q.push_back(relu_exp);
    drain("relu");

    // Reset one cycle after launch: in-flight vector must vanish
    tick(); drive(1'b1, mk(16'h0011, 16'h0022, 16'h0033));
    tick(); drive(1'b0, '0); rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_almost_full", almost_full, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_out_data", got_vec(), 0);
    tick(); drive(1'b0, '0); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(); drive(1'b0, '0);
      @(negedge clk);
      chk("mrst_no_vector", out_valid, 0);
    end
    chk("mrst_overflow_after", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws_result_drain.md
# ws_result_drain

Output drain stage that sits directly downstream of the bottom weight-stationary PE row of the systolic array. It takes the per-column partial sums that leave the array skewed in time (column i one cycle after column i-1), realigns them into one vector per output position, and buffers the vectors in a small FIFO. Vectors leave through a valid/ready handshake to the writeback/accumulation logic. An occupancy-plus-in-flight "almost_full" signal lets the fmap feeder throttle the array, because the array itself cannot stall.

## Interface
- out_word_size, 16, width of one partial-sum word (two's complement)
- row, 3, number of array columns and lanes per vector; minimum 1
- depth, 4, FIFO depth in vectors; power of two, depth >= row

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Result_in  input  [out_word_size-1:0] x [0:row-1]  skewed partial sums from the bottom PE row; lane i carries its word i cycles after lane 0
- in_valid  input  1  qualifies lane 0 of a new vector in the current cycle; lanes 1..row-1 of that vector are sampled in the following cycles without further qualification
- out_data  output  [out_word_size-1:0] x [0:row-1]  aligned vector at FIFO head
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts the head vector when high together with out_valid
- almost_full  output  1  (count + pending) >= depth
- count  output  $clog2(depth+1)  vectors currently stored
- overflow  output  1  sticky; a vector was dropped

## Operation
- Deskew: lane i passes through (row-1-i) registers; lane row-1 is combinational. in_valid passes through a (row-1)-stage valid delay line. The delay-line output is "wr_req", and the deskew outputs form the aligned vector "wr_data".
- pending: number of set bits in the valid delay line, i.e. vectors already launched but not yet written.
- Write: on wr_req, the vector is written at the tail if count < depth, or if count == depth and a read occurs in the same cycle.
- Drop: if wr_req arrives with the FIFO full and no read in that cycle, the vector is discarded and overflow sets. overflow stays set until rst.
- Read: when out_valid && out_ready, the head pointer advances.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Pointers: log2(depth) bits, natural wrap. Full and empty are derived from count, not from pointer compare.
- out_data is the registered FIFO head, valid whenever out_valid is high. It is held stable while out_valid && !out_ready.
- No arithmetic is performed on the data, except the optional ReLU described under Configuration.
- Reset, including mid-operation:
  - count = 0, pointers = 0, out_valid = 0, almost_full = 0, overflow = 0.
  - out_data = 0 and all deskew registers = 0.
  - Valid delay line cleared, so in-flight vectors are discarded.

## Timing
- Latency: in_valid with lane 0 at cycle t writes the vector at the end of cycle t+row-1. If the FIFO was empty, out_valid is high in cycle t+row.
- Throughput: one vector per cycle in and one out. in_valid may be asserted every cycle.
- almost_full is combinational from registered count and the delay line. The feeder samples it and stops asserting in_valid while it is high. A feeder that obeys it never causes overflow.
- count, out_valid and overflow are registered and update on the clock edge following the event.
- row == 1: no deskew registers. Write occurs in the same cycle as in_valid, and latency is 1.

## Configuration
- WS_DRAIN_RELU_EN defined: each lane of wr_data whose MSB is 1 is written as 0; non-negative words are written unchanged.
- WS_DRAIN_RELU_EN undefined: words are stored bit-exact.

## Test plan
- Single vector, row=3: lane0=5 at cycle 0, lane1=6 at cycle 1, lane2=7 at cycle 2, out_ready=1 -> out_valid high only in cycle 3 with out_data={5,6,7}; count returns to 0.
- Streaming with backpressure: 8 back-to-back vectors, out_ready low for 4 cycles, feeder obeys almost_full -> all vectors delivered in order; almost_full asserts before count reaches 4; overflow stays 0.
- Overflow: depth=4, out_ready=0, feeder ignores almost_full and issues 6 vectors -> count=4, vectors 5 and 6 dropped, overflow=1 until rst; out_data shows vector 1.
- Full plus simultaneous read/write: count=4, wr_req and handshake in the same cycle -> count stays 4, no overflow; the new vector appears at the tail.
- ReLU: lanes {-3, 0, 9} (0xFFFD, 0x0000, 0x0009) -> out_data {0,0,9} with WS_DRAIN_RELU_EN defined, {0xFFFD,0,9} without.
- Reset mid-flight: assert rst one cycle after in_valid -> all outputs 0 immediately; no vector emerges after rst deasserts; overflow=0.
